// File: rtl/conv_window_ctrl_if.sv
// rtl/conv_window_ctrl_if.sv - frame handshake and window-flag bundle for conv_window_ctrl
//
// Purpose: groups the per-frame control and status signals of the convolution
// window controller so producer and consumer connect through a single port.
// Signals:
//   start      frame start request (single cycle)
//   pix_valid  datapath input carries a valid pixel this cycle
//   busy       frame in progress (RUN or DRAIN)
//   col, row   position of the next pixel to be accepted
//   win_valid  datapath output is a valid window result this cycle
//   out_cnt    win_valid cycles since the last accepted start
//   done       one-cycle pulse when the frame is complete and drained
// Modports: master drives start/pix_valid, slave is the controller.
interface conv_window_ctrl_if #(
  parameter int CW = 6,
  parameter int OW = 16
);
  logic          start;
  logic          pix_valid;
  logic          busy;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          win_valid;
  logic [OW-1:0] out_cnt;
  logic          done;

  modport master (
    output start, pix_valid,
    input  busy, col, row, win_valid, out_cnt, done
  );

  modport slave (
    input  start, pix_valid,
    output busy, col, row, win_valid, out_cnt, done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - pixel/window sequencing controller for one conv layer
//
// Purpose: counts pixels over an IMG_W x IMG_H frame, flags cycles where a full
// K x K window is present, delays that flag PIPE_LAT stages to align with the
// datapath output, and brackets the frame with start/busy/done.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    conv_window_ctrl_if slave: start, pix_valid in; busy, col, row,
//          win_valid, out_cnt, done out
module conv_window_ctrl #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int K        = 5,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 6,
  parameter int OW       = 16
) (
  input  logic             clk,
  input  logic             reset,
  conv_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Drain counter needs at least one bit even when PIPE_LAT is 1.
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(IMG_H - 1);
  localparam logic [CW-1:0] WIN_FIRST  = CW'(K - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       col_q, row_q;
  logic [OW-1:0]       out_cnt_q;
  logic [DW-1:0]       drain_cnt;
  logic [PIPE_LAT-1:0] win_sr;

  logic accept, last_pix, raw_win, frame_start, busy_c, done_c;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    accept      = 1'b0;
    last_pix    = 1'b0;
    raw_win     = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        frame_start = bus.start;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c   = 1'b1;
        accept   = bus.pix_valid;
        last_pix = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
        raw_win  = accept && (row_q >= WIN_FIRST) && (col_q >= WIN_FIRST);
        if (last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Pixel position; the last pixel of the frame wraps both counters to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (frame_start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Counts the PIPE_LAT cycles needed for the last window to leave the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        drain_cnt <= '0;
    else if (state == DRAIN && drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
    else                                              drain_cnt <= '0;
  end

  // Free-running delay line matching the datapath register depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_sr <= '0;
    end else begin
      win_sr[0] <= raw_win;
      for (int i = 1; i < PIPE_LAT; i++) win_sr[i] <= win_sr[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     out_cnt_q <= '0;
    else if (frame_start)          out_cnt_q <= '0;
    else if (win_sr[PIPE_LAT-1])   out_cnt_q <= out_cnt_q + 1'b1;
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.col       = col_q;
  assign bus.row       = row_q;
  assign bus.win_valid = win_sr[PIPE_LAT-1];
  assign bus.out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - scoreboard bench for conv_window_ctrl
module tb_conv_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int PL = 2;
  localparam int CW = 6;
  localparam int OW = 16;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_ctrl_if #(.CW(CW), .OW(OW)) bus_a ();
  conv_window_ctrl_if #(.CW(CW), .OW(OW)) bus_b ();

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .PIPE_LAT(PL), .CW(CW), .OW(OW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  conv_window_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .PIPE_LAT(1), .CW(CW), .OW(OW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model of dut_a
  int m_st, m_row, m_col, m_dc, m_cnt;
  bit m_win;
  bit exp_q[$];
  int cyc;
  int pix_n, n_win, n_done, first_win_cyc, pix19_cyc, last_pix_cyc, done_cyc;

  task automatic model_reset();
    m_st = 0; m_row = 0; m_col = 0; m_dc = 0; m_cnt = 0; m_win = 0;
    exp_q.delete();
    repeat (PL - 1) exp_q.push_back(1'b0);
  endtask

  task automatic step(input bit st, input bit pv);
    bit raw, acc;
    acc = (m_st == 1) && pv;
    raw = acc && (m_row >= K - 1) && (m_col >= K - 1);
    exp_q.push_back(raw);
    bus_a.start = st;
    bus_a.pix_valid = pv;
    @(posedge clk);
    cyc++;
    if (acc) begin
      pix_n++;
      if (pix_n == 19) pix19_cyc = cyc;
      if (pix_n == W * H) last_pix_cyc = cyc;
    end
    if (m_st == 0 && st) m_cnt = 0;
    else if (m_win) m_cnt++;
    case (m_st)
      0: if (st) begin m_st = 1; m_row = 0; m_col = 0; end
      1: if (pv) begin
           if (m_col == W - 1) begin
             m_col = 0;
             if (m_row == H - 1) begin m_row = 0; m_st = 2; m_dc = 0; end
             else m_row++;
           end else m_col++;
         end
      2: if (m_dc == PL - 1) m_st = 3; else m_dc++;
      default: m_st = 0;
    endcase
    #1;
    m_win = exp_q.pop_front();
    check("win_valid", 32'(bus_a.win_valid), 32'(m_win));
    check("busy", 32'(bus_a.busy), 32'(m_st == 1 || m_st == 2));
    check("done", 32'(bus_a.done), 32'(m_st == 3));
    check("row", 32'(bus_a.row), m_row);
    check("col", 32'(bus_a.col), m_col);
    check("out_cnt", 32'(bus_a.out_cnt), m_cnt);
    if (bus_a.win_valid) begin
      n_win++;
      if (first_win_cyc < 0) first_win_cyc = cyc;
    end
    if (bus_a.done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic stats_clear();
    pix_n = 0; n_win = 0; n_done = 0;
    first_win_cyc = -1; pix19_cyc = -1; last_pix_cyc = -1; done_cyc = -1;
  endtask

  // Feeds pixels until the frame leaves RUN, then waits for done (bounded).
  task automatic finish_frame(input bit gap);
    int i, guard;
    i = 0;
    while (m_st == 1 && i < 400) begin
      step(1'b0, gap ? (i % 2 == 0) : 1'b1);
      i++;
    end
    guard = 0;
    while (n_done == 0 && guard < 20) begin
      step(1'b0, 1'b0);
      guard++;
    end
  endtask

  task automatic frame(input string tag, input bit gap, input bit do_start);
    stats_clear();
    if (do_start) step(1'b1, 1'b0);
    finish_frame(gap);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_win_pulses"}, n_win, NWIN);
    check({tag, "_out_cnt"}, 32'(bus_a.out_cnt), NWIN);
    check({tag, "_done_lat"}, done_cyc - last_pix_cyc, PL);
    if (!gap) check({tag, "_first_win_lat"}, first_win_cyc - pix19_cyc, PL - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_a.start = 0; bus_a.pix_valid = 0;
    bus_b.start = 0; bus_b.pix_valid = 0;
    cyc = 0;
    stats_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_col", 32'(bus_a.col), 0);
    check("rst_row", 32'(bus_a.row), 0);
    check("rst_win", 32'(bus_a.win_valid), 0);
    check("rst_out_cnt", 32'(bus_a.out_cnt), 0);
    check("rst_done", 32'(bus_a.done), 0);
    reset = 1'b0;
    model_reset();

    // Continuous frame
    frame("cont", 1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Pixel every other cycle
    frame("gap", 1'b1, 1'b1);
    step(1'b0, 1'b0);

    // Pixels while idle are ignored; start with no pixels; restart while busy
    stats_clear();
    repeat (10) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    check("idle_pix_col", 32'(bus_a.col), 0);
    check("idle_pix_row", 32'(bus_a.row), 0);
    check("idle_pix_no_win", n_win, 0);
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("restart_busy", 32'(bus_a.busy), 1);
    check("restart_col", 32'(bus_a.col), 6);
    finish_frame(1'b0);
    check("restart_out_cnt", 32'(bus_a.out_cnt), NWIN);
    step(1'b0, 1'b0);

    // Asynchronous reset mid-frame with windows in flight
    stats_clear();
    step(1'b1, 1'b0);
    for (int i = 0; i < 100 && !(m_row == 3 && m_col == 4); i++) step(1'b0, 1'b1);
    check("mid_row", 32'(bus_a.row), 3);
    check("mid_col", 32'(bus_a.col), 4);
    bus_a.pix_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus_a.busy), 0);
    check("abort_col", 32'(bus_a.col), 0);
    check("abort_row", 32'(bus_a.row), 0);
    check("abort_win", 32'(bus_a.win_valid), 0);
    check("abort_out_cnt", 32'(bus_a.out_cnt), 0);
    check("abort_done", 32'(bus_a.done), 0);
    @(posedge clk);
    #1;
    check("abort_hold_win", 32'(bus_a.win_valid), 0);
    check("abort_hold_done", 32'(bus_a.done), 0);
    reset = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    frame("after_abort", 1'b0, 1'b1);

    // Back-to-back: start in the done cycle is ignored, next one is taken
    step(1'b1, 1'b0);
    check("b2b_start_in_done_busy", 32'(bus_a.busy), 0);
    step(1'b1, 1'b0);
    check("b2b_start_in_idle_busy", 32'(bus_a.busy), 1);
    frame("b2b", 1'b0, 1'b0);
    step(1'b0, 1'b0);

    // 3x3 frame, K=3, PIPE_LAT=1
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    check("b_busy", 32'(bus_b.busy), 1);
    bus_b.pix_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      check(i < 8 ? "b_win_early" : "b_win_last", 32'(bus_b.win_valid), i < 8 ? 0 : 1);
      check("b_done_early", 32'(bus_b.done), 0);
    end
    bus_b.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b_done", 32'(bus_b.done), 1);
    check("b_win_after", 32'(bus_b.win_valid), 0);
    check("b_out_cnt", 32'(bus_b.out_cnt), 1);
    check("b_busy_at_done", 32'(bus_b.busy), 0);
    @(posedge clk);
    #1;
    check("b_done_one_cycle", 32'(bus_b.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
